// File: rtl/hs32_mem_pkg.sv
// hs32_mem_pkg: shared types and constants for the HS32 two-port memory arbiter.
//   state_t       arbiter FSM state (IDLE / BUSY / DONE)
//   port_t        requester id; PORT_F = instruction fetch, PORT_D = load/store
//   bus_req_t     latched bus request (address, write data, direction)
//   TIMEOUT_DATA  read data returned when a bus cycle times out
package hs32_mem_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic port_t;

    localparam port_t PORT_F = 1'b0;
    localparam port_t PORT_D = 1'b1;

    localparam logic [DW-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] dtw;
        logic          rw;
    } bus_req_t;

endpackage

// File: rtl/hs32_mem_arbiter_if.sv
// hs32_mem_arbiter_if: strobe/acknowledge external memory bus.
//   mem_addr  bus address             (master -> slave)
//   mem_dtw   bus write data          (master -> slave)
//   mem_rw    1 = write, 0 = read     (master -> slave)
//   mem_stb   bus cycle active        (master -> slave)
//   mem_dtr   bus read data           (slave -> master)
//   mem_ack   bus cycle complete      (slave -> master)
interface hs32_mem_arbiter_if;
    import hs32_mem_pkg::*;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dtw;
    logic          mem_rw;
    logic          mem_stb;
    logic [DW-1:0] mem_dtr;
    logic          mem_ack;

    modport master (
        output mem_addr,
        output mem_dtw,
        output mem_rw,
        output mem_stb,
        input  mem_dtr,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_dtw,
        input  mem_rw,
        input  mem_stb,
        output mem_dtr,
        output mem_ack
    );

endinterface

// File: rtl/hs32_mem_wdt.sv
// hs32_mem_wdt: bus-cycle watchdog.
//   clk, rst  clock and synchronous active-high reset
//   clear     restart the count from zero
//   enable    count one cycle of an outstanding bus cycle
//   expired   registered; high once TIMEOUT enabled cycles have elapsed since clear
module hs32_mem_wdt #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TW-1:0] cnt;
    logic          expired_q;

    // Count freezes once expired so the flag stays up until the next clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt       <= '0;
            expired_q <= 1'b0;
        end else if (enable && !expired_q) begin
            cnt       <= cnt + TW'(1);
            expired_q <= ((cnt + TW'(1)) == TW'(TIMEOUT));
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/hs32_mem_arbiter.sv
// hs32_mem_arbiter: two-port (fetch F / load-store D) arbiter onto one
// strobe/acknowledge memory bus, with fair alternation, flush kill of fetch
// responses and a bus-cycle timeout.
//   clk, rst          clock, synchronous active-high reset
//   flush             pipeline flush; kills an in-flight fetch response
//   f_addr, f_reqm    fetch request (read only)
//   f_dtr, f_ackm     fetch read data, one-cycle done pulse
//   d_addr, d_dtw,
//   d_rw, d_reqm      load/store request
//   d_dtr, d_ackm,
//   d_err             load data, one-cycle done pulse, timeout flag
//   mem               memory bus master port
module hs32_mem_arbiter
    import hs32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [AW-1:0]             f_addr,
    input  logic                      f_reqm,
    output logic [DW-1:0]             f_dtr,
    output logic                      f_ackm,
    input  logic [AW-1:0]             d_addr,
    input  logic [DW-1:0]             d_dtw,
    input  logic                      d_rw,
    input  logic                      d_reqm,
    output logic [DW-1:0]             d_dtr,
    output logic                      d_ackm,
    output logic                      d_err,
    hs32_mem_arbiter_if.master        mem
);

    state_t        state_q, state_d;
    port_t         owner_q, owner_d;
    port_t         last_q, last_d;
    logic          killed_q, killed_d;
    logic          tmo_q, tmo_d;
    bus_req_t      req_q, req_d;
    logic          stb_q, stb_d;
    logic [DW-1:0] f_dtr_q, f_dtr_d;
    logic          f_ackm_q, f_ackm_d;
    logic [DW-1:0] d_dtr_q, d_dtr_d;
    logic          d_ackm_q, d_ackm_d;

    logic          f_elig;
    logic          grant_f;
    logic          grant_d;
    logic          finish;
    logic          resp_tmo;
    logic [DW-1:0] resp_data;
    logic          wdt_clear;
    logic          wdt_enable;
    logic          wdt_expired;

    hs32_mem_wdt #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clear   (wdt_clear),
        .enable  (wdt_enable),
        .expired (wdt_expired)
    );

    // Fair grant: a lone eligible request wins; under contention the port
    // that was not granted last goes next. Flush masks fetch eligibility.
    always_comb begin
        f_elig  = f_reqm && !flush;
        grant_d = d_reqm && (!f_elig || (last_q == PORT_F));
        grant_f = f_elig && (!d_reqm || (last_q == PORT_D));
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= PORT_F;
            last_q   <= PORT_F;
            killed_q <= 1'b0;
            tmo_q    <= 1'b0;
            req_q    <= '0;
            stb_q    <= 1'b0;
            f_dtr_q  <= '0;
            f_ackm_q <= 1'b0;
            d_dtr_q  <= '0;
            d_ackm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            killed_q <= killed_d;
            tmo_q    <= tmo_d;
            req_q    <= req_d;
            stb_q    <= stb_d;
            f_dtr_q  <= f_dtr_d;
            f_ackm_q <= f_ackm_d;
            d_dtr_q  <= d_dtr_d;
            d_ackm_q <= d_ackm_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        killed_d   = killed_q;
        tmo_d      = tmo_q;
        req_d      = req_q;
        stb_d      = stb_q;
        f_dtr_d    = f_dtr_q;
        f_ackm_d   = 1'b0;
        d_dtr_d    = d_dtr_q;
        d_ackm_d   = 1'b0;
        wdt_clear  = 1'b1;
        wdt_enable = 1'b0;
        finish     = 1'b0;
        resp_tmo   = 1'b0;
        resp_data  = mem.mem_dtr;

        unique case (state_q)
            IDLE: begin
                killed_d = 1'b0;
                tmo_d    = 1'b0;
                if (grant_f || grant_d) begin
                    owner_d    = grant_d ? PORT_D : PORT_F;
                    last_d     = grant_d ? PORT_D : PORT_F;
                    req_d.addr = grant_d ? d_addr : f_addr;
                    req_d.rw   = grant_d && d_rw;
                    req_d.dtw  = (grant_d && d_rw) ? d_dtw : '0;
                    stb_d      = 1'b1;
                    state_d    = BUSY;
                end
            end

            BUSY: begin
                wdt_clear  = 1'b0;
                wdt_enable = 1'b1;
                if ((owner_q == PORT_F) && flush) begin
                    killed_d = 1'b1;
                end
                // An ack in the expiry cycle still counts as a normal completion.
                if (mem.mem_ack) begin
                    finish = 1'b1;
                end else if (wdt_expired) begin
                    finish    = 1'b1;
                    resp_tmo  = 1'b1;
                    resp_data = TIMEOUT_DATA;
                end
                if (finish) begin
                    stb_d   = 1'b0;
                    state_d = DONE;
                    if (owner_q == PORT_F) begin
                        // A flush in this very cycle kills the response too.
                        if (!(killed_q || flush)) begin
                            f_ackm_d = 1'b1;
                            f_dtr_d  = resp_data;
                        end
                    end else begin
                        d_ackm_d = 1'b1;
                        d_dtr_d  = resp_data;
                        // tmo drives d_err directly, so only D timeouts raise it.
                        tmo_d    = resp_tmo;
                    end
                end
            end

            DONE: begin
                tmo_d   = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign f_dtr        = f_dtr_q;
    assign f_ackm       = f_ackm_q;
    assign d_dtr        = d_dtr_q;
    assign d_ackm       = d_ackm_q;
    assign d_err        = tmo_q;
    assign mem.mem_addr = req_q.addr;
    assign mem.mem_dtw  = req_q.dtw;
    assign mem.mem_rw   = req_q.rw;
    assign mem.mem_stb  = stb_q;

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// tb_hs32_mem_arbiter: scoreboard bench for hs32_mem_arbiter (TIMEOUT = 4).
// Memory responder latency is a function of the bus address (addr[4:2]) or a
// directed override; read data is a fixed pattern of the address.
module tb_hs32_mem_arbiter;
    import hs32_mem_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_reqm = 1'b0;
    logic [31:0] f_dtr;
    logic        f_ackm;
    logic [31:0] d_addr = '0;
    logic [31:0] d_dtw = '0;
    logic        d_rw = 1'b0;
    logic        d_reqm = 1'b0;
    logic [31:0] d_dtr;
    logic        d_ackm;
    logic        d_err;

    hs32_mem_arbiter_if mem_if ();

    hs32_mem_arbiter #(
        .TIMEOUT (TMO),
        .TW      (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .f_addr (f_addr),
        .f_reqm (f_reqm),
        .f_dtr  (f_dtr),
        .f_ackm (f_ackm),
        .d_addr (d_addr),
        .d_dtw  (d_dtw),
        .d_rw   (d_rw),
        .d_reqm (d_reqm),
        .d_dtr  (d_dtr),
        .d_ackm (d_ackm),
        .d_err  (d_err),
        .mem    (mem_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus knobs shared by responder and requesters.
    int          fixed_lat  = -1;
    bit          use_fixed  = 1'b0;
    logic [31:0] fixed_data = '0;
    bit          stray      = 1'b0;
    bit          chk_stb    = 1'b1;
    bit          fair_chk   = 1'b0;

    // Scoreboard queues and monitor statistics.
    logic [31:0] f_q[$];
    logic [32:0] d_q[$];
    int f_acks = 0;
    int d_acks = 0;
    int f_base = 0;
    int d_base = 0;

    // Observed bus cycle (first strobe cycle) and its strobe length.
    logic [31:0] bus_dtw = '0;
    logic        bus_rw = 1'b0;
    int          last_stb_cycles = 0;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int lat_of(input logic [31:0] a);
        return (fixed_lat >= 0) ? fixed_lat : int'(a[4:2]);
    endfunction

    // Reference: ack within TIMEOUT stb cycles returns bus data, otherwise timeout.
    function automatic logic [32:0] model(input logic [31:0] a);
        if (lat_of(a) <= TMO) return {1'b0, (use_fixed ? fixed_data : pattern(a))};
        return {1'b1, TIMEOUT_DATA};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no ack within cycle budget", name);
    endtask

    // Memory responder: acks after the chosen latency, checks the bus request.
    initial begin : responder
        bit in_cyc;
        int cyc;
        int cur_lat;
        bit ok;
        in_cyc = 1'b0;
        cyc = 0;
        cur_lat = 0;
        mem_if.mem_ack = 1'b0;
        mem_if.mem_dtr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_if.mem_stb) begin
                if (!in_cyc) begin
                    in_cyc  = 1'b1;
                    cyc     = 0;
                    cur_lat = lat_of(mem_if.mem_addr);
                    bus_rw  = mem_if.mem_rw;
                    bus_dtw = mem_if.mem_dtw;
                    if (mem_if.mem_rw)
                        ok = d_reqm && d_rw && (mem_if.mem_addr == d_addr) && (mem_if.mem_dtw == d_dtw);
                    else
                        ok = (mem_if.mem_dtw == 32'h0) &&
                             ((f_reqm && (mem_if.mem_addr == f_addr)) ||
                              (d_reqm && !d_rw && (mem_if.mem_addr == d_addr)));
                    check("bus_request", 64'(ok), 64'd1);
                end else begin
                    cyc++;
                end
                mem_if.mem_ack = stray || (cyc == cur_lat);
                mem_if.mem_dtr = use_fixed ? fixed_data : pattern(mem_if.mem_addr);
            end else begin
                if (in_cyc) begin
                    in_cyc = 1'b0;
                    last_stb_cycles = cyc + 1;
                    if (chk_stb)
                        check("stb_length", 64'(cyc + 1), 64'((cur_lat <= TMO) ? cur_lat + 1 : TMO + 1));
                end
                mem_if.mem_ack = stray;
            end
        end
    end

    // Monitor: pops the scoreboard on every ack pulse.
    initial begin : monitor
        logic [31:0] fe;
        logic [32:0] de;
        forever begin
            @(posedge clk);
            #1;
            if (f_ackm) begin
                f_acks++;
                if (f_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL f_unexpected_ack: got f_ackm=1 f_dtr=%h expected no ack", f_dtr);
                end else begin
                    fe = f_q.pop_front();
                    check("f_dtr", 64'(f_dtr), 64'(fe));
                    if (fair_chk) check("f_fairness", 64'((d_acks - f_base) <= 1), 64'd1);
                end
            end
            if (d_ackm) begin
                d_acks++;
                if (d_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL d_unexpected_ack: got d_ackm=1 d_dtr=%h expected no ack", d_dtr);
                end else begin
                    de = d_q.pop_front();
                    check("d_dtr", 64'(d_dtr), 64'(de[31:0]));
                    check("d_err", 64'(d_err), 64'(de[32]));
                    if (fair_chk) check("d_fairness", 64'((f_acks - d_base) <= 1), 64'd1);
                end
            end
        end
    end

    task automatic wait_ack(input bit port_d, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(port_d ? d_ackm : f_ackm) && cyc < 60);
        if (!(port_d ? d_ackm : f_ackm)) bound_fail(port_d ? "d_wait" : "f_wait");
    endtask

    task automatic wait_any(output bit got_d);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(f_ackm || d_ackm) && cyc < 60);
        if (!(f_ackm || d_ackm)) bound_fail("any_wait");
        got_d = d_ackm;
    endtask

    task automatic pulse_rst();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stb"}, 64'(mem_if.mem_stb), 64'd0);
        check({tag, "_flags"}, 64'({f_ackm, d_ackm, d_err, mem_if.mem_rw}), 64'd0);
        check({tag, "_dtr"}, {f_dtr, d_dtr}, 64'd0);
        check({tag, "_bus"}, {mem_if.mem_addr, mem_if.mem_dtw}, 64'd0);
    endtask

    task automatic f_requester(input int n);
        int k;
        logic [31:0] a;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            a = $urandom & 32'hFFFF_FFFC;
            f_addr = a;
            f_reqm = 1'b1;
            f_base = d_acks;
            f_q.push_back(model(a)[31:0]);
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!f_ackm && k < 80);
            if (!f_ackm) bound_fail("f_rand_wait");
            f_reqm = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic d_requester(input int n);
        int k;
        logic [31:0] a;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            a = $urandom & 32'hFFFF_FFFC;
            d_addr = a;
            d_rw   = 1'($urandom_range(0, 1));
            d_dtw  = $urandom;
            d_reqm = 1'b1;
            d_base = f_acks;
            d_q.push_back(model(a));
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!d_ackm && k < 80);
            if (!d_ackm) bound_fail("d_rand_wait");
            d_reqm = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : main
        int cyc;
        int acks0;
        int fl_lat[3];
        int fl_at[3];
        bit got_d;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Single fetch, ack on first strobe cycle.
        fixed_lat  = 0;
        use_fixed  = 1'b1;
        fixed_data = 32'hDEAD_BEEF;
        @(negedge clk);
        f_addr = 32'h0000_0010;
        f_reqm = 1'b1;
        f_q.push_back(32'hDEAD_BEEF);
        wait_ack(1'b0, cyc);
        check("f_read_latency", 64'(cyc), 64'd2);
        check("f_read_rw", 64'(bus_rw), 64'd0);
        @(negedge clk) f_reqm = 1'b0;
        use_fixed = 1'b0;

        // Data write with three wait cycles.
        fixed_lat = 3;
        @(negedge clk);
        d_addr = 32'h0000_0100;
        d_dtw  = 32'h1234_5678;
        d_rw   = 1'b1;
        d_reqm = 1'b1;
        d_q.push_back(model(32'h0000_0100));
        wait_ack(1'b1, cyc);
        check("d_write_latency", 64'(cyc), 64'd5);
        check("d_write_rw", 64'(bus_rw), 64'd1);
        check("d_write_dtw", 64'(bus_dtw), 64'h1234_5678);
        @(negedge clk);
        d_reqm = 1'b0;
        d_rw   = 1'b0;

        // Continuous contention from reset: D, F, D, F, D.
        pulse_rst();
        fixed_lat = 1;
        @(negedge clk);
        f_addr = 32'h0000_1000;
        d_addr = 32'h0000_2000;
        f_reqm = 1'b1;
        d_reqm = 1'b1;
        f_q.push_back(model(f_addr)[31:0]);
        d_q.push_back(model(d_addr));
        for (int k = 1; k <= 5; k++) begin
            wait_any(got_d);
            check($sformatf("grant_order_%0d", k), 64'(got_d), 64'(k % 2));
            @(negedge clk);
            if (k <= 3) begin
                if (got_d) begin
                    d_addr = d_addr + 32'd4;
                    d_q.push_back(model(d_addr));
                end else begin
                    f_addr = f_addr + 32'd4;
                    f_q.push_back(model(f_addr)[31:0]);
                end
            end else if (got_d) begin
                d_reqm = 1'b0;
            end else begin
                f_reqm = 1'b0;
            end
        end

        // Flush kills in-flight fetch responses, including same-cycle ack.
        fl_lat = '{3, 0, 2};
        fl_at  = '{1, 0, 2};
        for (int t = 0; t < 3; t++) begin
            fixed_lat = fl_lat[t];
            @(negedge clk);
            f_addr = 32'h0000_0040 + 32'(t * 4);
            f_reqm = 1'b1;
            repeat (fl_at[t] + 1) @(negedge clk);
            flush  = 1'b1;
            f_reqm = 1'b0;
            @(negedge clk) flush = 1'b0;
            acks0 = f_acks;
            repeat (6) @(negedge clk);
            check($sformatf("flush_kill_%0d", t), 64'(f_acks - acks0), 64'd0);
            f_addr = 32'h0000_0080 + 32'(t * 4);
            f_reqm = 1'b1;
            f_q.push_back(model(f_addr)[31:0]);
            wait_ack(1'b0, cyc);
            check($sformatf("after_flush_latency_%0d", t), 64'(cyc), 64'(fl_lat[t] + 2));
            @(negedge clk) f_reqm = 1'b0;
        end

        // Data read that never gets an ack times out.
        fixed_lat = 99;
        @(negedge clk);
        d_addr = 32'h0000_0300;
        d_rw   = 1'b0;
        d_reqm = 1'b1;
        d_q.push_back({1'b1, 32'hFFFF_FFFF});
        wait_ack(1'b1, cyc);
        check("timeout_latency", 64'(cyc), 64'(TMO + 2));
        @(negedge clk);
        d_reqm = 1'b0;
        check("timeout_stb_cycles", 64'(last_stb_cycles), 64'(TMO + 1));

        // Reset mid-transaction, then a stray ack.
        chk_stb = 1'b0;
        @(negedge clk);
        f_addr = 32'h0000_0500;
        f_reqm = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        f_reqm = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        @(negedge clk) rst = 1'b0;
        acks0 = f_acks + d_acks;
        @(negedge clk) stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_ack_ignored", 64'(f_acks + d_acks - acks0), 64'd0);
        chk_stb = 1'b1;

        // Randomized traffic on both ports.
        fixed_lat = -1;
        fair_chk  = 1'b1;
        fork
            f_requester(40);
            d_requester(40);
        join
        repeat (5) @(negedge clk);
        fair_chk = 1'b0;
        check("f_queue_drained", 64'(f_q.size()), 64'd0);
        check("d_queue_drained", 64'(d_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hs32_mem_arbiter.md
# hs32_mem_arbiter

Two-port memory arbiter between the HS32 core and the external memory bus. Port F serves the instruction fetch stage (read-only); port D serves the execute stage (load/store). It serializes requests onto a single strobe/acknowledge memory bus, alternates grants fairly under contention, discards fetch responses across a pipeline flush, and aborts bus cycles that exceed a timeout.

## Interface
- TIMEOUT, 255: max cycles `mem_stb` may stay high without `mem_ack`; range 1..255.
- TW, 8: timeout counter width; must satisfy TIMEOUT < 2^TW.

Ports (clock and reset first):
- clk  in  1  core clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush from the pipeline controller.
- f_addr  in  32  fetch word address.
- f_reqm  in  1  fetch request valid.
- f_dtr  out  32  fetch read data.
- f_ackm  out  1  fetch data valid; one-cycle pulse.
- d_addr  in  32  data address.
- d_dtw  in  32  store data.
- d_rw  in  1  1 = write, 0 = read.
- d_reqm  in  1  data request valid.
- d_dtr  out  32  load data.
- d_ackm  out  1  data done; one-cycle pulse.
- d_err  out  1  timeout flag; valid only with `d_ackm`.
- mem_addr  out  32  bus address.
- mem_dtw  out  32  bus write data.
- mem_rw  out  1  bus direction.
- mem_stb  out  1  bus cycle active.
- mem_dtr  in  32  bus read data.
- mem_ack  in  1  bus cycle complete.

## Operation
- FSM states: IDLE, BUSY, DONE. Registered `owner` (F/D) and `last` (last granted port).
- IDLE: grant selection.
  - Only one eligible request: that port is granted.
  - Both eligible: grant the port != `last`.
  - F is eligible only if `f_reqm && !flush`.
  - On grant: latch address, write data and rw (F is always read). Set `owner` and `last`. Clear the timer. Go to BUSY.
- BUSY: `mem_stb` = 1; `mem_*` are driven from the latched values.
  - On `mem_ack`: capture `mem_dtr` and go to DONE.
  - Else, when the timer reaches TIMEOUT: capture 32'hFFFF_FFFF, set `tmo`, go to DONE.
  - Else: increment the timer.
- DONE: `mem_stb` = 0; one-cycle pulse on the owner's ack; then IDLE.
  - F owner: `f_ackm` = 1 unless `killed`. A timeout on port F returns 32'hFFFF_FFFF with no error flag.
  - D owner: `d_ackm` = 1, `d_err` = `tmo`.
- Flush: `flush` high while `owner` = F in BUSY sets `killed`. The bus cycle still completes normally. `killed` suppresses `f_ackm` in DONE and clears on return to IDLE. `flush` never affects port D.
- Requester contract:
  - Hold `reqm` and the address stable until `ackm`.
  - Dropping `reqm` before `ackm` does not cancel a granted cycle.
  - `reqm` still high in the cycle after `ackm` is treated as a new request.
- `f_dtr` and `d_dtr` hold their last captured value between acks. `mem_dtw` is 0 for reads.

## Timing
- Reset values: state IDLE, `last` = F, `killed` = 0, `tmo` = 0. All outputs 0, including `mem_stb`, both ackm, `d_err` and all data/address outputs.
- `rst` mid-transaction: `mem_stb` is low the next cycle and no ack pulse is issued. A late `mem_ack` is ignored in IDLE.
- Latency, request seen in IDLE at cycle N:
  - `mem_stb` goes high at N+1.
  - With `mem_ack` at N+1+k: ack pulse at N+2+k; earliest next grant at N+3+k.
  - Minimum 3 cycles per transaction.
- Timeout: with `mem_stb` first high at cycle S and no `mem_ack`, `mem_stb` is last high at S+TIMEOUT. DONE is at S+TIMEOUT+1.
- Simultaneous events:
  - `mem_ack` and timer expiry in the same cycle: `mem_ack` wins and `tmo` = 0.
  - `flush` in the same cycle as `mem_ack` in BUSY: the response is killed.
  - `flush` during DONE with F owner: no effect; the ack is issued.
- `mem_ack` outside BUSY is ignored.

## Structure
- Package `hs32_mem_pkg`: state enum (IDLE/BUSY/DONE), port-id constants (PORT_F, PORT_D), constant TIMEOUT_DATA = 32'hFFFF_FFFF.
- One sub-module, `hs32_mem_wdt`:
  - Ports: clear, enable, expired.
  - Parameters: TIMEOUT, TW.
- Everything else is flat in `hs32_mem_arbiter`.

## Test plan
- Single F read at 0x0000_0010 with `mem_ack` on the first stb cycle, `mem_dtr` = 0xDEADBEEF -> `f_ackm` 2 cycles after the request, `f_dtr` = 0xDEADBEEF, `mem_rw` = 0.
- D write to 0x100, `d_dtw` = 0x12345678, `mem_ack` after 3 wait cycles -> `mem_rw` = 1, `mem_dtw` = 0x12345678, `d_ackm` at N+5, `d_err` = 0.
- F and D both requesting continuously from reset -> grant order D, F, D, F. No port ever waits more than one transaction.
- F read in BUSY, `flush` pulsed, then `mem_ack` -> no `f_ackm`; next F request after flush served normally.
- D read with TIMEOUT = 4 and `mem_ack` never asserted -> `mem_stb` high exactly 5 cycles; `d_ackm` with `d_err` = 1 and `d_dtr` = 0xFFFFFFFF.
- `rst` asserted in BUSY -> next cycle `mem_stb` = 0 and all outputs 0; a later stray `mem_ack` produces no ack.
